sync_timing_rx: RTL and testbench

SYNC_TIMING_RX -- requirements
Module: sync_timing_rx

---
 rtl/video_timing_pkg.sv | 26 ++
 rtl/sync_edge_det.sv | 25 ++
 rtl/sync_timing_rx.sv | 165 ++++++++++++++++
 tb/tb_sync_timing_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 timing constants and the sync receiver FSM state type,
// common to the timing generator and sync_timing_rx.
package video_timing_pkg;

    localparam int unsigned H_TOTAL_DEF  = 800;
    localparam int unsigned H_START_DEF  = 144;
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_TOTAL_DEF  = 525;
    localparam int unsigned V_START_DEF  = 35;
    localparam int unsigned V_ACTIVE_DEF = 480;

    localparam logic [10:0] HCNT_MAX = 11'h7FF;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } rx_state_t;

    function automatic logic in_window(input logic [10:0] v,
                                       input logic [10:0] lo,
                                       input logic [10:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers an active-low sync input once and flags its falling edge
// (registered high, input low) as a registered one-cycle pulse.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sync_n_i,
    output logic fall_o
);

    logic sync_q;
    logic fall_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_n_i;
            fall_q <= sync_q & ~sync_n_i;
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/sync_timing_rx.sv
// Recovers pixel/line position from hsync_n/vsync_n and qualifies it with a lock FSM.
// Defining SYNC_TIMING_RX_STATS_EN adds the lock_loss_cnt output.
//   state      | meaning
//   ST_SEARCH  | no timing, waiting for a vsync edge
//   ST_MEASURE | timing one whole frame of line lengths and line count
//   ST_LOCKED  | timing verified every line and frame, outputs valid
module sync_timing_rx
    import video_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL  = H_TOTAL_DEF,
    parameter int unsigned V_TOTAL  = V_TOTAL_DEF,
    parameter int unsigned H_START  = H_START_DEF,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_START  = V_START_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic        clk25m,
    input  logic        rst_n,
    input  logic        hsync_n,
    input  logic        vsync_n,
    output logic [9:0]  xpos,
    output logic [9:0]  ypos,
    output logic        active,
    output logic        locked,
    output logic        frame_start
`ifdef SYNC_TIMING_RX_STATS_EN
    ,
    output logic [15:0] lock_loss_cnt
`endif
);

    localparam logic [11:0] H_LEN = 12'(H_TOTAL);
    localparam logic [10:0] V_LEN = 11'(V_TOTAL);
    localparam logic [10:0] H_LO  = 11'(H_START);
    localparam logic [10:0] H_HI  = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] V_LO  = 11'(V_START);
    localparam logic [10:0] V_HI  = 11'(V_START + V_ACTIVE);

    logic        hs_fall;
    logic        vs_fall;
    rx_state_t   state_q, state_d;
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic        line_ok;
    logic        frame_ok;
    logic        sync_lost;
    logic        active_d, active_q;
    logic [9:0]  xpos_d, xpos_q;
    logic [9:0]  ypos_d, ypos_q;
    logic        frame_start_d, frame_start_q;
    logic        locked_q;

    sync_edge_det u_hs_det (
        .clk_i    (clk25m),
        .rst_n_i  (rst_n),
        .sync_n_i (hsync_n),
        .fall_o   (hs_fall)
    );

    sync_edge_det u_vs_det (
        .clk_i    (clk25m),
        .rst_n_i  (rst_n),
        .sync_n_i (vsync_n),
        .fall_o   (vs_fall)
    );

    // The count seen on an edge is one short of the interval it closes.
    assign line_ok   = ({1'b0, hcnt_q} + 12'd1) == H_LEN;
    assign frame_ok  = ({1'b0, vcnt_q} + 11'd1) == V_LEN;
    assign sync_lost = (hcnt_q == HCNT_MAX);

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (hs_fall) begin
            hcnt_d = '0;
        end else if (!sync_lost) begin
            hcnt_d = hcnt_q + 11'd1;
        end
        if (vs_fall) begin
            vcnt_d = '0;
        end else if (hs_fall) begin
            vcnt_d = vcnt_q + 10'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_SEARCH: begin
                if (vs_fall) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (hs_fall && !line_ok) begin
                    state_d = ST_SEARCH;
                end else if (vs_fall) begin
                    state_d = frame_ok ? ST_LOCKED : ST_MEASURE;
                end
            end
            ST_LOCKED: begin
                if ((hs_fall && !line_ok) || (vs_fall && !frame_ok)) state_d = ST_SEARCH;
            end
            default: state_d = ST_SEARCH;
        endcase
        if (sync_lost) state_d = ST_SEARCH;
    end

    // Outputs are registered from next-state values so they line up with hcnt/vcnt.
    always_comb begin
        active_d = (state_d == ST_LOCKED)
                   && in_window(hcnt_d, H_LO, H_HI)
                   && in_window({1'b0, vcnt_d}, V_LO, V_HI);
        xpos_d = '0;
        ypos_d = '0;
        if (active_d) begin
            xpos_d = 10'(hcnt_d - H_LO);
            ypos_d = 10'({1'b0, vcnt_d} - V_LO);
        end
        frame_start_d = (state_q == ST_LOCKED) && vs_fall;
    end

    always_ff @(posedge clk25m or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_SEARCH;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            active_q      <= 1'b0;
            xpos_q        <= '0;
            ypos_q        <= '0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            active_q      <= active_d;
            xpos_q        <= xpos_d;
            ypos_q        <= ypos_d;
            locked_q      <= (state_d == ST_LOCKED);
            frame_start_q <= frame_start_d;
        end
    end

    assign xpos        = xpos_q;
    assign ypos        = ypos_q;
    assign active      = active_q;
    assign locked      = locked_q;
    assign frame_start = frame_start_q;

`ifdef SYNC_TIMING_RX_STATS_EN
    logic [15:0] loss_cnt_q;

    always_ff @(posedge clk25m or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_q <= '0;
        end else if ((state_q == ST_LOCKED) && (state_d == ST_SEARCH)
                     && (loss_cnt_q != 16'hFFFF)) begin
            loss_cnt_q <= loss_cnt_q + 16'd1;
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_sync_timing_rx.sv
// Bench for sync_timing_rx on a reduced raster, with a cycle-level reference model
// built from pin edge spacing and randomised sync widths, phase, bad-line and reset position.
module tb_sync_timing_rx;

    localparam int HT = 100;
    localparam int HS = 20;
    localparam int HA = 64;
    localparam int VT = 12;
    localparam int VS = 3;
    localparam int VA = 8;

    logic       clk25m  = 1'b0;
    logic       rst_n   = 1'b0;
    logic       hsync_n = 1'b1;
    logic       vsync_n = 1'b1;
    logic [9:0] xpos;
    logic [9:0] ypos;
    logic       active;
    logic       locked;
    logic       frame_start;
`ifdef SYNC_TIMING_RX_STATS_EN
    logic [15:0] lock_loss_cnt;
`endif

    sync_timing_rx #(
        .H_TOTAL  (HT),
        .V_TOTAL  (VT),
        .H_START  (HS),
        .H_ACTIVE (HA),
        .V_START  (VS),
        .V_ACTIVE (VA)
    ) dut (
        .clk25m      (clk25m),
        .rst_n       (rst_n),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .xpos        (xpos),
        .ypos        (ypos),
        .active      (active),
        .locked      (locked),
        .frame_start (frame_start)
`ifdef SYNC_TIMING_RX_STATS_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    always #20 clk25m = ~clk25m;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // reference model state
    bit   m_hprev = 1'b1, m_vprev = 1'b1, m_hfall = 1'b0, m_vfall = 1'b0;
    int   m_base = 0, m_vline = 0, m_stage = 0, m_loss = 0;
    logic       e_locked = 1'b0, e_active = 1'b0, e_fs = 1'b0;
    logic [9:0] e_x = '0, e_y = '0;

    // observed events
    int   rise_cyc = -1, fall_cyc = -1, fs_count = 0;
    logic prev_locked = 1'b0;
    int   frame_d0 = 0, bad_next = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic chk_stats(input int want);
`ifdef SYNC_TIMING_RX_STATS_EN
        check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(want));
`endif
    endtask

    // Expected outputs after clock edge 'cyc', from pin samples seen so far.
    task automatic model_edge();
        bit hs_ev, vs_ev, line_ok, frame_ok, lost;
        int prev, hpos;
        if (!rst_n) begin
            m_hprev = 1'b1; m_vprev = 1'b1; m_hfall = 1'b0; m_vfall = 1'b0;
            m_base = cyc; m_vline = 0; m_stage = 0; m_loss = 0;
            e_locked = 1'b0; e_active = 1'b0; e_fs = 1'b0; e_x = '0; e_y = '0;
            return;
        end
        hs_ev    = m_hfall;
        vs_ev    = m_vfall;
        line_ok  = (cyc - m_base) == HT;
        frame_ok = (m_vline + 1) == VT;
        lost     = (cyc - 1 - m_base) >= 2047;
        prev     = m_stage;
        case (m_stage)
            0: if (vs_ev) m_stage = 1;
            1: begin
                if (hs_ev && !line_ok) m_stage = 0;
                else if (vs_ev) m_stage = frame_ok ? 2 : 1;
            end
            default: if ((hs_ev && !line_ok) || (vs_ev && !frame_ok)) m_stage = 0;
        endcase
        if (lost) m_stage = 0;
        if (prev == 2 && m_stage == 0 && m_loss < 65535) m_loss++;
        e_fs = vs_ev && (prev == 2);
        if (vs_ev) m_vline = 0;
        else if (hs_ev) m_vline = (m_vline + 1) % 1024;
        if (hs_ev) m_base = cyc;
        hpos = cyc - m_base;
        if (hpos > 2047) hpos = 2047;
        e_locked = (m_stage == 2);
        e_active = e_locked && hpos >= HS && hpos < HS + HA && m_vline >= VS && m_vline < VS + VA;
        e_x = e_active ? 10'(hpos - HS) : 10'd0;
        e_y = e_active ? 10'(m_vline - VS) : 10'd0;
        m_hfall = m_hprev && !hsync_n;
        m_hprev = hsync_n;
        m_vfall = m_vprev && !vsync_n;
        m_vprev = vsync_n;
    endtask

    task automatic tick(input logic h, input logic v);
        @(posedge clk25m);
        cyc++;
        #1;
        model_edge();
        check("outs", 32'({locked, active, frame_start, xpos, ypos}),
                      32'({e_locked, e_active, e_fs, e_x, e_y}));
`ifdef SYNC_TIMING_RX_STATS_EN
        check("loss_cnt_cycle", 32'(lock_loss_cnt), 32'(m_loss));
`endif
        if (locked && !prev_locked) rise_cyc = cyc;
        if (!locked && prev_locked) fall_cyc = cyc;
        prev_locked = locked;
        if (frame_start) fs_count++;
        hsync_n = h;
        vsync_n = v;
    endtask

    // One frame; optional short line, active-window probes and a 3-cycle reset.
    task automatic send_frame(input int nlines, input int bad_line, input bit pos,
                              input int rst_line, input int rst_col);
        int hw, vw, len, k;
        hw = int'($urandom_range(4, 12));
        vw = int'($urandom_range(1, 2));
        frame_d0 = cyc + 1;
        for (int l = 0; l < nlines; l++) begin
            len = (l == bad_line) ? HT - 1 : HT;
            for (int c = 0; c < len; c++) begin
                if (l == bad_line + 1 && c == 0) bad_next = cyc + 1;
                if (l == rst_line && c == rst_col) begin
                    rst_n = 1'b0;
                    #1;
                    check("reset_async", 32'({locked, active, frame_start, xpos, ypos}), 32'd0);
                end
                if (l == rst_line && c == rst_col + 3) rst_n = 1'b1;
                tick((c < hw) ? 1'b0 : 1'b1, (l < vw) ? 1'b0 : 1'b1);
                if (pos) begin
                    k = cyc - frame_d0 - 2;
                    if (k == VS * HT + HS - 1)
                        check("before_first", 32'(active), 32'd0);
                    if (k == VS * HT + HS)
                        check("first_pixel", 32'({active, xpos, ypos}), {11'd0, 1'b1, 10'd0, 10'd0});
                    if (k == (VS + VA - 1) * HT + HS + HA - 1)
                        check("last_pixel", 32'({active, xpos, ypos}),
                              32'({1'b1, 10'(HA - 1), 10'(VA - 1)}));
                    if (k == (VS + VA - 1) * HT + HS + HA)
                        check("after_last", 32'(active), 32'd0);
                end
            end
        end
    endtask

    initial begin
        int d0, s, bl;

        rst_n = 1'b0;
        repeat (3) tick(1'b1, 1'b1);
        rst_n = 1'b1;
        check("reset_outs", 32'({locked, active, frame_start, xpos, ypos}), 32'd0);
        chk_stats(0);
        repeat (int'($urandom_range(0, HT))) tick(1'b1, 1'b1);

        // acquire: lock at the second vsync plus two clocks, no pulse on entry
        rise_cyc = -1; fs_count = 0;
        send_frame(VT, -1, 1'b0, -1, -1);
        send_frame(VT, -1, 1'b0, -1, -1);
        d0 = frame_d0;
        check("lock_rise", 32'(rise_cyc), 32'(d0 + 2));
        check("no_fs_on_entry", 32'(fs_count), 32'd0);
        check("locked_hold", 32'(locked), 32'd1);
        send_frame(VT, -1, 1'b1, -1, -1);
        check("fs_per_frame", 32'(fs_count), 32'd1);

        // one short line drops lock; one good measured frame relocks
        bl = int'($urandom_range(1, VT - 2));
        fall_cyc = -1;
        send_frame(VT, bl, 1'b0, -1, -1);
        check("bad_line_drop", 32'(fall_cyc), 32'(bad_next + 2));
        chk_stats(1);
        rise_cyc = -1;
        send_frame(VT, -1, 1'b0, -1, -1);
        send_frame(VT, -1, 1'b0, -1, -1);
        check("relock", 32'(rise_cyc), 32'(frame_d0 + 2));

        // hsync stuck high: saturation forces SEARCH
        send_frame(VT, -1, 1'b0, -1, -1);
        s = frame_d0 + (VT - 1) * HT;
        fall_cyc = -1;
        repeat (2100) tick(1'b1, 1'b1);
        check("sync_loss_fall", 32'(fall_cyc), 32'(s + 2050));
        check("sync_loss_outs", 32'({locked, active}), 32'd0);
        chk_stats(2);

        // short frame while measuring restarts the measurement
        rise_cyc = -1;
        send_frame(VT - 1, -1, 1'b0, -1, -1);
        send_frame(VT, -1, 1'b0, -1, -1);
        check("no_lock_short_measure", 32'(rise_cyc), 32'hFFFF_FFFF);
        send_frame(VT, -1, 1'b0, -1, -1);
        check("lock_after_restart", 32'(rise_cyc), 32'(frame_d0 + 2));

        // short frame while locked drops lock at the following vsync
        send_frame(VT - 1, -1, 1'b0, -1, -1);
        fall_cyc = -1;
        send_frame(VT, -1, 1'b0, -1, -1);
        check("short_frame_drop", 32'(fall_cyc), 32'(frame_d0 + 2));
        chk_stats(3);
        rise_cyc = -1;
        send_frame(VT, -1, 1'b0, -1, -1);
        send_frame(VT, -1, 1'b0, -1, -1);
        check("relock_after_short", 32'(rise_cyc), 32'(frame_d0 + 2));

        // reset mid-frame: needs a full measured frame afterwards
        send_frame(VT, -1, 1'b0, int'($urandom_range(3, VT - 1)), int'($urandom_range(0, HT - 4)));
        chk_stats(0);
        rise_cyc = -1;
        send_frame(VT, -1, 1'b0, -1, -1);
        check("no_lock_after_reset", 32'(rise_cyc), 32'hFFFF_FFFF);
        send_frame(VT, -1, 1'b0, -1, -1);
        check("lock_after_reset", 32'(rise_cyc), 32'(frame_d0 + 2));
        repeat (5) tick(1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
